// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: drives the instruction ROM and buffers {pc, inst} pairs for ID.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [31:0]     pc;
  logic            run;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            full;
  logic            pop;
  logic            unused_low;

  assign unused_low = ^redirect_pc[1:0];

  // Fetch gating never looks at id_ready, so there is no id_ready -> rom_ce path.
  assign full     = (count == CW'(DEPTH));
  assign rom_ce   = run && !fetch_stall && !full && !redirect;
  assign rom_addr = pc;
  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready && !redirect;
  assign id_inst  = id_valid ? mem[rd_ptr].inst : 32'h0;
  assign id_pc    = id_valid ? mem[rd_ptr].pc   : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      run    <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        pc     <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (rom_ce) begin
          wr_ptr <= wr_ptr + PW'(1);
          pc     <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({rom_ce, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; count==0 already marks every
  // slot as dead, and the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (rom_ce) mem[wr_ptr] <= '{pc: pc, inst: rom_inst};
  end

`ifdef IF_PERF_CNT_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, perf_flushed} + 33'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (rom_ce) perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule
